mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_pkg.sv | 33 +++
 rtl/mdu_alu.sv | 43 ++++
 rtl/mdu_ctrl.sv | 123 ++++++++++++
 tb/tb_mdu_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared MD-unit constants: op codes, FSM states and MIPS funct codes.
// Imported by the multiply/divide controller and its arithmetic core.
package mdu_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } md_state_e;

    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_DIVU  = 6'h1b;

    function automatic logic is_multi(input logic [2:0] op);
        return op <= 3'd3;
    endfunction

endpackage

// File: rtl/mdu_alu.sv
// Combinational multiply/divide core: product or quotient/remainder
// for the latched operands, plus a divide-by-zero flag.
module mdu_alu
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    logic        sgn;
    logic [63:0] ax;
    logic [63:0] bx;
    logic [63:0] prod;
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] q;
    logic [31:0] r;

    always_comb begin
        sgn = (op == OP_MULT) || (op == OP_DIV);
        ax = {{32{sgn & a[31]}}, a};
        bx = {{32{sgn & b[31]}}, b};
        prod = ax * bx;
        // Magnitude division keeps 0x80000000 / -1 well defined.
        ua = (sgn && a[31]) ? -a : a;
        ub = (sgn && b[31]) ? -b : b;
        div_by_zero = (b == 32'd0);
        if (div_by_zero) ub = 32'd1;
        q = ua / ub;
        r = ua % ub;
        hi = prod[63:32];
        lo = prod[31:0];
        if ((op == OP_DIV) || (op == OP_DIVU)) begin
            lo = (sgn && (a[31] ^ b[31])) ? -q : q;
            hi = (sgn && a[31]) ? -r : r;
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MD-unit controller: issue, busy countdown, HI/LO ownership and
// the D-stage stall request.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        cancel,
    input  logic        D_md_use,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_state_e   state;
    md_state_e   state_d;
    logic [3:0]  cnt;
    logic [3:0]  cnt_d;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        accept;
    logic        latch;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_d;
    logic [31:0] lo_d;
    logic [31:0] alu_hi;
    logic [31:0] alu_lo;
    logic        alu_dz;

    mdu_alu u_alu (
        .op          (op_q),
        .a           (a_q),
        .b           (b_q),
        .hi          (alu_hi),
        .lo          (alu_lo),
        .div_by_zero (alu_dz)
    );

    assign accept = start & ~cancel & (state == IDLE);
    assign busy   = (state != IDLE);
    // Reset masks the issue term so stall is quiet while held in reset.
    assign stall  = reset & D_md_use & (busy | (start & ~cancel & is_multi(op)));

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        latch   = 1'b0;
        hi_we   = 1'b0;
        lo_we   = 1'b0;
        hi_d    = alu_hi;
        lo_d    = alu_lo;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            state_d = MUL;
                            cnt_d   = 4'(MULT_CYCLES - 1);
                            latch   = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = DIV;
                            cnt_d   = 4'(DIV_CYCLES - 1);
                            latch   = 1'b1;
                        end
                        OP_MTHI: begin
                            hi_we = 1'b1;
                            hi_d  = rs_data;
                        end
                        OP_MTLO: begin
                            lo_we = 1'b1;
                            lo_d  = rs_data;
                        end
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                if (cnt == 4'd0) begin
                    state_d = IDLE;
                    hi_we   = ~((state == DIV) & alu_dz);
                    lo_we   = ~((state == DIV) & alu_dz);
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            op_q  <= 3'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            HI    <= 32'd0;
            LO    <= 32'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            if (latch) begin
                op_q <= op;
                a_q  <= rs_data;
                b_q  <= rt_data;
            end
            if (hi_we) HI <= hi_d;
            if (lo_we) LO <= lo_d;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed MD ops, completion results
// checked by a monitor on each busy falling edge.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        cancel;
    logic        D_md_use;
    logic        busy;
    logic        stall;
    logic [31:0] HI;
    logic [31:0] LO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    res_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    logic prev_busy = 1'b0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .cancel   (cancel),
        .D_md_use (D_md_use),
        .busy     (busy),
        .stall    (stall),
        .HI       (HI),
        .LO       (LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every completion (busy falling) consumes one expectation.
    always @(negedge clk) begin
        if (prev_busy && !busy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_completion", 32'd1, 32'd0);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                chk("result_hi", HI, e.hi);
                chk("result_lo", LO, e.lo);
            end
        end
        prev_busy <= busy;
    end

    task automatic do_op(
        input string       nm,
        input logic [2:0]  o,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        c,
        input logic        dmu,
        input int          exp_busy,
        input logic [31:0] ehi,
        input logic [31:0] elo,
        input int          cancel_at,
        input int          rst_at
    );
        int n;
        if (exp_busy > 0) exp_q.push_back('{hi: ehi, lo: elo});
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        cancel = c; D_md_use = dmu;
        #1;
        chk({nm, "_stall_issue"}, 32'(stall), 32'(dmu & ~c & (o <= 3'd3)));
        @(negedge clk);
        start = 1'b0; cancel = 1'b0;
        rs_data = $urandom; rt_data = $urandom;
        #1;
        n = 0;
        while (busy && n < 40) begin
            if (n == rst_at) begin
                reset = 1'b0; start = 1'b1; op = 3'd0;
                #1;
                chk({nm, "_stall_in_reset"}, 32'(stall), 32'd0);
                chk({nm, "_busy_in_reset"}, 32'(busy), 32'd0);
                n++;
                @(negedge clk);
                reset = 1'b1; start = 1'b0;
                #1;
                break;
            end
            chk({nm, "_stall_busy"}, 32'(stall), 32'(dmu));
            n++;
            cancel = (n == cancel_at);
            @(negedge clk);
            #1;
        end
        cancel = 1'b0;
        chk({nm, "_busy_cycles"}, 32'(n), 32'(exp_busy));
        chk({nm, "_stall_after"}, 32'(stall), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; start = 1'b1; op = 3'd0; cancel = 1'b0;
        D_md_use = 1'b1; rs_data = 32'hFFFF_FFFF; rt_data = 32'h2;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        do_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1, 5,
              32'hFFFF_FFFF, 32'hFFFF_FFFA, -1, -1);
        do_op("multu", 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 5,
              32'h0000_0002, 32'hFFFF_FFFA, -1, -1);
        do_op("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 10,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, -1, -1);
        do_op("divu_zero", 3'd3, 32'd7, 32'd0, 1'b0, 1'b0, 10,
              32'hFFFF_FFFF, 32'hFFFF_FFFD, -1, -1);
        do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 10,
              32'h0000_0000, 32'h8000_0000, -1, -1);
        do_op("divu", 3'd3, 32'hFFFF_FFFF, 32'h10, 1'b0, 1'b0, 10,
              32'h0000_000F, 32'h0FFF_FFFF, -1, -1);

        do_op("mult_cancel", 3'd0, 32'd5, 32'd5, 1'b1, 1'b1, 0,
              32'd0, 32'd0, -1, -1);
        chk("cancel_hi", HI, 32'h0000_000F);
        chk("cancel_lo", LO, 32'h0FFF_FFFF);

        do_op("mult_midcancel", 3'd0, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1, 5,
              32'h0000_0001, 32'h0000_0000, 2, -1);

        do_op("mtlo", 3'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b1, 0,
              32'd0, 32'd0, -1, -1);
        chk("mtlo_lo", LO, 32'h1234_5678);
        chk("mtlo_hi", HI, 32'h0000_0001);
        do_op("mthi", 3'd4, 32'hCAFE_BABE, 32'd0, 1'b0, 1'b0, 0,
              32'd0, 32'd0, -1, -1);
        chk("mthi_hi", HI, 32'hCAFE_BABE);
        chk("mthi_lo", LO, 32'h1234_5678);
        do_op("reserved", 3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0, 1'b1, 0,
              32'd0, 32'd0, -1, -1);
        chk("reserved_hi", HI, 32'hCAFE_BABE);
        chk("reserved_lo", LO, 32'h1234_5678);

        do_op("div_reset", 3'd2, 32'd100, 32'd7, 1'b0, 1'b1, 3,
              32'd0, 32'd0, -1, 2);
        repeat (15) @(negedge clk);
        #1;
        chk("post_reset_hi", HI, 32'd0);
        chk("post_reset_lo", LO, 32'd0);
        chk("post_reset_busy", 32'(busy), 32'd0);

        repeat (2) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
